// File: rtl/gene_feeder.sv
// Host-loaded A/B sequence buffer that streams query bases into PE_array.
// Emits the array clear pulse, one A base per cycle, a fixed drain wait and a done pulse.
module gene_feeder #(
    parameter int LEN_B     = 64,
    parameter int MAX_A     = 64,
    parameter int DRAIN_CYC = 66,
    localparam int AW       = $clog2((MAX_A > LEN_B) ? MAX_A : LEN_B),
    localparam int LW       = $clog2(MAX_A) + 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_wr_en,
    input  logic               i_wr_sel,
    input  logic [AW-1:0]      i_wr_addr,
    input  logic [1:0]         i_wr_data,
    input  logic [LW-1:0]      i_len_a,
    input  logic               i_go,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_arr_rst,
    output logic               o_start,
    output logic [1:0]         o_A,
    output logic [2*LEN_B-1:0] o_B
);

    // state     | meaning
    // ST_IDLE   | waiting for i_go; host writes accepted
    // ST_STREAM | first cycle clears the array, then one A base per cycle
    // ST_DRAIN  | waiting DRAIN_CYC cycles for the wavefront to leave the array
    // ST_DONE   | single cycle that registers o_done; host writes accepted

    localparam int IW = (MAX_A > 1) ? $clog2(MAX_A) : 1;
    localparam int CW = $clog2(DRAIN_CYC) + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_STREAM, ST_DRAIN, ST_DONE} state_t;

    state_t          state, state_nxt;
    logic [1:0]      mem_a [MAX_A];
    logic [LW-1:0]   len_q, len_nxt;
    logic [LW-1:0]   idx_q, idx_nxt;
    logic [CW-1:0]   cnt_q, cnt_nxt;
    logic            first_q, first_nxt;
    logic            busy_nxt, done_nxt, arr_rst_nxt, start_nxt;
    logic [1:0]      a_nxt;
    logic            wr_ok, a_ok, b_ok, len_ok;

    assign wr_ok  = i_wr_en && (state == ST_IDLE || state == ST_DONE);
    assign a_ok   = {1'b0, i_wr_addr} < (AW+1)'(MAX_A);
    assign b_ok   = {1'b0, i_wr_addr} < (AW+1)'(LEN_B);
    assign len_ok = (i_len_a != '0) && (i_len_a <= LW'(MAX_A));

    always_comb begin
        state_nxt   = state;
        len_nxt     = len_q;
        idx_nxt     = idx_q;
        cnt_nxt     = cnt_q;
        first_nxt   = 1'b0;
        arr_rst_nxt = 1'b0;
        start_nxt   = 1'b0;
        a_nxt       = 2'b00;
        done_nxt    = 1'b0;
        busy_nxt    = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (i_go && len_ok) begin
                    state_nxt = ST_STREAM;
                    len_nxt   = i_len_a;
                    idx_nxt   = '0;
                    cnt_nxt   = '0;
                    first_nxt = 1'b1;
                end
            end
            ST_STREAM: begin
                if (first_q) begin
                    arr_rst_nxt = 1'b1;
                end else begin
                    start_nxt = 1'b1;
                    a_nxt     = mem_a[idx_q[IW-1:0]];
                    idx_nxt   = idx_q + LW'(1);
                    if (idx_q == len_q - LW'(1)) state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                cnt_nxt = cnt_q + CW'(1);
                if (cnt_q == CW'(DRAIN_CYC - 1)) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done_nxt  = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= ST_IDLE;
            len_q     <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            first_q   <= 1'b0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_arr_rst <= 1'b0;
            o_start   <= 1'b0;
            o_A       <= 2'b00;
            o_B       <= '0;
        end else begin
            state     <= state_nxt;
            len_q     <= len_nxt;
            idx_q     <= idx_nxt;
            cnt_q     <= cnt_nxt;
            first_q   <= first_nxt;
            o_busy    <= busy_nxt;
            o_done    <= done_nxt;
            o_arr_rst <= arr_rst_nxt;
            o_start   <= start_nxt;
            o_A       <= a_nxt;
            if (wr_ok && i_wr_sel && b_ok) o_B[2*int'(i_wr_addr) +: 2] <= i_wr_data;
        end
    end

    // A buffer survives reset so a run can be repeated after an abort.
    always_ff @(posedge i_clk) begin
        if (wr_ok && !i_wr_sel && a_ok) mem_a[i_wr_addr[IW-1:0]] <= i_wr_data;
    end

endmodule

// File: tb/tb_gene_feeder.sv
// Directed bench for gene_feeder: reset, nominal/short runs, invalid lengths,
// busy-time writes and go, same-cycle write+go, and mid-run reset.
module tb_gene_feeder;

    localparam int LEN_B     = 64;
    localparam int MAX_A     = 64;
    localparam int DRAIN_CYC = 66;

    logic         i_clk = 1'b0;
    logic         i_rst = 1'b1;
    logic         i_wr_en = 1'b0;
    logic         i_wr_sel = 1'b0;
    logic [5:0]   i_wr_addr = '0;
    logic [1:0]   i_wr_data = '0;
    logic [6:0]   i_len_a = '0;
    logic         i_go = 1'b0;
    logic         o_busy, o_done, o_arr_rst, o_start;
    logic [1:0]   o_A;
    logic [127:0] o_B;

    logic [1:0]   tb_a [MAX_A];
    logic [127:0] exp_b;
    int           n_pass = 0;
    int           n_total = 0;

    gene_feeder #(.LEN_B(LEN_B), .MAX_A(MAX_A), .DRAIN_CYC(DRAIN_CYC)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_wr_en(i_wr_en), .i_wr_sel(i_wr_sel),
        .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data), .i_len_a(i_len_a), .i_go(i_go),
        .o_busy(o_busy), .o_done(o_done), .o_arr_rst(o_arr_rst), .o_start(o_start),
        .o_A(o_A), .o_B(o_B)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    task automatic wr(input bit sel, input int addr, input logic [1:0] d);
        i_wr_en   = 1'b1;
        i_wr_sel  = sel;
        i_wr_addr = addr[5:0];
        i_wr_data = d;
        @(negedge i_clk);
        i_wr_en   = 1'b0;
    endtask

    task automatic load_b();
        exp_b = '0;
        for (int j = 0; j < LEN_B; j++) begin
            logic [1:0] v;
            v = 2'(3 - (j % 4));
            exp_b[2*j +: 2] = v;
            wr(1'b1, j, v);
        end
    endtask

    // Issues i_go at the current negedge and checks the full run timeline.
    task automatic do_run(input int len, input bit wr_busy, input bit go_busy);
        i_go    = 1'b1;
        i_len_a = 7'(len);
        @(negedge i_clk);                       // edge k
        i_go    = 1'b0;
        i_wr_en = 1'b0;
        @(negedge i_clk);                       // k+1
        check("arr_rst_pulse", o_arr_rst, 1);
        check("busy_rise", o_busy, 1);
        check("start_pre", o_start, 0);
        for (int n = 0; n < len; n++) begin
            if (wr_busy && n == 20) begin
                i_wr_en = 1'b1; i_wr_sel = 1'b0; i_wr_addr = 6'd30; i_wr_data = ~tb_a[30];
            end else if (wr_busy && n == 21) begin
                i_wr_en = 1'b1; i_wr_sel = 1'b1; i_wr_addr = 6'd5; i_wr_data = ~exp_b[11:10];
            end else begin
                i_wr_en = 1'b0;
            end
            @(negedge i_clk);                   // k+2+n
            check("stream_start", o_start, 1);
            check("stream_a", o_A, tb_a[n]);
            if (n == 0) check("arr_rst_low", o_arr_rst, 0);
        end
        i_wr_en = 1'b0;
        @(negedge i_clk);                       // k+2+len
        check("start_fall", o_start, 0);
        check("a_zero_idle", o_A, 0);
        check("busy_drain", o_busy, 1);
        if (go_busy) begin
            i_go    = 1'b1;
            i_len_a = 7'd5;
        end
        repeat (DRAIN_CYC - 1) @(negedge i_clk);
        check("done_early", o_done, 0);
        @(negedge i_clk);                       // k+2+len+DRAIN
        check("done_pulse", o_done, 1);
        check("busy_at_done", o_busy, 1);
        check("b_held", o_B, exp_b);
        i_go = 1'b0;
        @(negedge i_clk);                       // k+3+len+DRAIN
        check("done_one_cycle", o_done, 0);
        check("busy_fall", o_busy, 0);
        @(negedge i_clk);
        check("no_rerun_busy", o_busy, 0);
        check("no_rerun_rst", o_arr_rst, 0);
    endtask

    initial begin
        bit seen_done;
        exp_b = '0;
        repeat (2) @(negedge i_clk);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_arr_rst", o_arr_rst, 0);
        check("rst_start", o_start, 0);
        check("rst_a", o_A, 0);
        check("rst_b", o_B, 128'h0);
        i_rst = 1'b0;

        for (int i = 0; i < MAX_A; i++) begin
            tb_a[i] = 2'(i % 4);
            wr(1'b0, i, tb_a[i]);
        end
        load_b();
        check("b_loaded", o_B, exp_b);

        do_run(64, 1'b0, 1'b0);                 // nominal
        do_run(64, 1'b1, 1'b1);                 // writes during STREAM, go during DRAIN/DONE
        do_run(1, 1'b0, 1'b0);                  // shortest run

        i_go = 1'b1; i_len_a = 7'd0;
        @(negedge i_clk);
        i_go = 1'b0;
        @(negedge i_clk);
        check("len0_busy", o_busy, 0);
        check("len0_arr_rst", o_arr_rst, 0);
        i_go = 1'b1; i_len_a = 7'd65;
        @(negedge i_clk);
        i_go = 1'b0;
        @(negedge i_clk);
        check("len65_busy", o_busy, 0);
        check("len65_arr_rst", o_arr_rst, 0);

        i_wr_en = 1'b1; i_wr_sel = 1'b0; i_wr_addr = 6'd0; i_wr_data = 2'd2;
        tb_a[0] = 2'd2;
        do_run(4, 1'b0, 1'b0);                  // same-cycle write and go

        i_go = 1'b1; i_len_a = 7'd64;
        @(negedge i_clk);                       // edge k
        i_go = 1'b0;
        repeat (11) @(negedge i_clk);           // idx = 10
        check("pre_abort_a", o_A, tb_a[9]);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        check("abort_start", o_start, 0);
        check("abort_busy", o_busy, 0);
        check("abort_b", o_B, 128'h0);
        check("abort_a", o_A, 0);
        seen_done = 1'b0;
        for (int c = 0; c < DRAIN_CYC + 70; c++) begin
            @(negedge i_clk);
            if (o_done || o_busy) seen_done = 1'b1;
        end
        check("abort_no_done", seen_done, 0);
        exp_b = '0;
        load_b();
        do_run(12, 1'b0, 1'b0);                 // retained A contents

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
